// File: rtl/sparse_chunk_encoder.sv
// +------------------------------------------------------------------------+
// | sparse_chunk_encoder: dense beats -> sparsemap + compacted nonzero     |
// | bytes, 2-stage stall-propagating pipeline with per-chunk beat counting.|
// | Optional: SPARSE_ENC_NZCOUNT_EN enables the per-chunk nonzero count.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module sparse_chunk_encoder #(
  parameter int MEM_SIZE = 128,
  parameter int BUS_SIZE = 8,
  localparam int NZ_W = $clog2(MEM_SIZE) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BUS_SIZE*8-1:0] dense_data_i,
  input  logic                  dense_valid_i,
  input  logic                  dense_last_i,
  output logic                  dense_ready_o,
  output logic [BUS_SIZE-1:0]   sparsemap_o,
  output logic [BUS_SIZE*8-1:0] nonzero_data_o,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic                  chunk_end_o,
  output logic [NZ_W-1:0]       nz_count_o
);

  localparam int BEATS = MEM_SIZE / BUS_SIZE;
  localparam int CNT_W = $clog2(BEATS);
  localparam int SEL_W = $clog2(BUS_SIZE);
  localparam int W     = BUS_SIZE * 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic                s1_valid_q, s2_valid_q;
  logic [W-1:0]        s1_data_q, s2_data_q;
  logic [BUS_SIZE-1:0] s1_map_q, s2_map_q;
  logic                s1_end_q, s2_end_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BUS_SIZE-1:0] in_map;
  logic                in_end, s1_load, s2_load;
  logic [W-1:0]        compact;
  logic [SEL_W-1:0]    slot;

  for (genvar gi = 0; gi < BUS_SIZE; gi++) begin : g_map
    assign in_map[gi] = |dense_data_i[gi*8 +: 8];
  end

  // Ready looks through a full pipe when the output is being drained this cycle.
  assign dense_ready_o = !s1_valid_q || !s2_valid_q || wr_ready_i;
  assign s1_load       = dense_valid_i && dense_ready_o;
  assign s2_load       = s1_valid_q && (!s2_valid_q || wr_ready_i);
  assign in_end        = (cnt_q == LAST_BEAT) || dense_last_i;
  assign cnt_d         = in_end ? '0 : cnt_q + 1'b1;

  // Each nonzero byte goes to the next free output slot in ascending order.
  always_comb begin
    compact = '0;
    slot    = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      if (s1_map_q[i]) begin
        compact[{slot, 3'b000} +: 8] = s1_data_q[i*8 +: 8];
        slot = slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_map_q   <= '0;
      s1_end_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= dense_data_i;
        s1_map_q   <= in_map;
        s1_end_q   <= in_end;
        cnt_q      <= cnt_d;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_map_q   <= '0;
      s2_end_q   <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_q <= 1'b1;
        s2_data_q  <= compact;
        s2_map_q   <= s1_map_q;
        s2_end_q   <= s1_end_q;
      end else if (wr_ready_i) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign wr_valid_o     = s2_valid_q;
  assign sparsemap_o    = s2_map_q;
  assign nonzero_data_o = s2_data_q;
  assign chunk_end_o    = s2_end_q;

`ifdef SPARSE_ENC_NZCOUNT_EN
  logic [NZ_W-1:0] acc_q, nz_q, popcnt, total;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      popcnt = popcnt + NZ_W'(s1_map_q[i]);
    end
  end

  assign total = acc_q + popcnt;

  // The chunk total rides with the chunk-end beat; every other beat reports 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      nz_q  <= '0;
    end else if (s2_load) begin
      if (s1_end_q) begin
        nz_q  <= total;
        acc_q <= '0;
      end else begin
        nz_q  <= '0;
        acc_q <= total;
      end
    end
  end

  assign nz_count_o = nz_q;
`else
  assign nz_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sparse_chunk_encoder.sv
// Self-checking bench for sparse_chunk_encoder: table-driven beats plus
// multi-cycle sequences (latency, full/short chunks, backpressure, async reset).
`default_nettype none

module tb_sparse_chunk_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] dense_data_i;
  logic        dense_valid_i;
  logic        dense_last_i;
  logic        dense_ready_o;
  logic [7:0]  sparsemap_o;
  logic [63:0] nonzero_data_o;
  logic        wr_valid_o;
  logic        wr_ready_i;
  logic        chunk_end_o;
  logic [7:0]  nz_count_o;

  sparse_chunk_encoder #(.MEM_SIZE(128), .BUS_SIZE(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .dense_data_i   (dense_data_i),
    .dense_valid_i  (dense_valid_i),
    .dense_last_i   (dense_last_i),
    .dense_ready_o  (dense_ready_o),
    .sparsemap_o    (sparsemap_o),
    .nonzero_data_o (nonzero_data_o),
    .wr_valid_o     (wr_valid_o),
    .wr_ready_i     (wr_ready_i),
    .chunk_end_o    (chunk_end_o),
    .nz_count_o     (nz_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  map;
    logic [63:0] comp;
  } vec_t;

  typedef struct {
    logic [7:0]  map;
    logic [63:0] comp;
    logic        ende;
    logic [7:0]  nz;
  } exp_t;

  vec_t vec [8];
  exp_t exp_q [$];

  int passed = 0;
  int total  = 0;
  int cur_vec = 0;
  int mcnt = 0;
  int macc = 0;
  int n_out = 0, n_acc = 0, n_end = 0, stalls = 0;
  logic [7:0] last_end_nz = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic note_fail(input string nm);
    total++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Reference model: expected beats queued at acceptance, compared at transfer.
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      mcnt = 0;
      macc = 0;
    end else begin
      if (wr_valid_o && wr_ready_i) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_output");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_map",  {56'd0, sparsemap_o}, {56'd0, e.map});
          chk("out_data", nonzero_data_o, e.comp);
          chk("out_end",  {63'd0, chunk_end_o}, {63'd0, e.ende});
          chk("out_nz",   {56'd0, nz_count_o}, {56'd0, e.nz});
        end
        n_out++;
        if (chunk_end_o) begin
          n_end++;
          last_end_nz = nz_count_o;
        end
      end
      if (dense_valid_i && dense_ready_o) begin
        exp_t e;
        e.map  = vec[cur_vec].map;
        e.comp = vec[cur_vec].comp;
        e.ende = (mcnt == 15) || dense_last_i;
        e.nz   = 8'd0;
`ifdef SPARSE_ENC_NZCOUNT_EN
        macc = macc + $countones(vec[cur_vec].map);
        if (e.ende) begin
          e.nz = 8'(macc);
          macc = 0;
        end
`endif
        mcnt = e.ende ? 0 : mcnt + 1;
        exp_q.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic drive(input int vi, input logic last);
    cur_vec      = vi;
    dense_data_i = vec[vi].data;
    dense_last_i = last;
  endtask

  task automatic send_beat(input int vi, input logic last);
    logic r;
    drive(vi, last);
    dense_valid_i = 1'b1;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk_i);
      r = dense_ready_o;
      @(posedge clk_i);
      #1;
      if (r) return;
      stalls++;
    end
    note_fail("send_timeout");
  endtask

  task automatic idle(input int n);
    dense_valid_i = 1'b0;
    dense_last_i  = 1'b0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    dense_valid_i = 1'b0;
    dense_last_i  = 1'b0;
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, e0, a0, s0;
    logic r;
    logic [7:0]  snap_map;
    logic [63:0] snap_data;

    vec[0] = '{64'h0005_0000_0700_0003, 8'h49, 64'h0000_0000_0005_0703};
    vec[1] = '{64'h0000_0000_0000_0000, 8'h00, 64'h0000_0000_0000_0000};
    vec[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vec[3] = '{64'h8000_0000_0000_0000, 8'h80, 64'h0000_0000_0000_0080};
    vec[4] = '{64'h0000_0000_0000_0001, 8'h01, 64'h0000_0000_0000_0001};
    vec[5] = '{64'h1100_2200_3300_4400, 8'hAA, 64'h0000_0000_1122_3344};
    vec[6] = '{64'h0102_0304_0506_0708, 8'hFF, 64'h0102_0304_0506_0708};
    vec[7] = '{64'h00AB_0000_0000_CD00, 8'h42, 64'h0000_0000_0000_ABCD};

    rst_i = 1'b1;
    wr_ready_i = 1'b1;
    dense_valid_i = 1'b0;
    dense_last_i = 1'b0;
    dense_data_i = '0;
    #2;
    chk("rst_wr_valid", {63'd0, wr_valid_o}, 64'd0);
    chk("rst_map", {56'd0, sparsemap_o}, 64'd0);
    chk("rst_data", nonzero_data_o, 64'd0);
    chk("rst_end", {63'd0, chunk_end_o}, 64'd0);
    chk("rst_nz", {56'd0, nz_count_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rst_release_ready", {63'd0, dense_ready_o}, 64'd1);

    // Single-beat latency and compaction.
    drive(0, 1'b0);
    dense_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    dense_valid_i = 1'b0;
    chk("lat_not_yet", {63'd0, wr_valid_o}, 64'd0);
    @(posedge clk_i);
    #1;
    chk("lat_valid", {63'd0, wr_valid_o}, 64'd1);
    chk("lat_map", {56'd0, sparsemap_o}, 64'h49);
    chk("lat_data", nonzero_data_o, 64'h0000_0000_0005_0703);
    chk("lat_end", {63'd0, chunk_end_o}, 64'd0);
    idle(2);

    // Table vectors, back to back.
    for (int i = 0; i < 8; i++) send_beat(i, 1'b0);
    idle(3);

    // Full chunk of 16 plus one beat of the next chunk, at full throughput.
    do_reset();
    n0 = n_out; e0 = n_end; s0 = stalls;
    for (int i = 0; i < 17; i++) send_beat(i % 8, 1'b0);
    dense_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    chk("full_out_count", 64'(n_out - n0), 64'd17);
    chk("full_no_stall", 64'(stalls - s0), 64'd0);
    chk("full_end_count", 64'(n_end - e0), 64'd1);
    idle(2);

    // Backpressure: 5 cycles of wr_ready_i low under continuous input.
    do_reset();
    a0 = n_acc;
    snap_map = '0;
    snap_data = '0;
    begin
      int idx;
      idx = 0;
      drive(0, 1'b0);
      dense_valid_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
        wr_ready_i = (c >= 5);
        @(negedge clk_i);
        r = dense_ready_o;
        if (c == 2) begin
          snap_map = sparsemap_o;
          snap_data = nonzero_data_o;
        end
        if (c == 4) begin
          chk("bp_accepted", 64'(n_acc - a0), 64'd2);
          chk("bp_ready_low", {63'd0, dense_ready_o}, 64'd0);
          chk("bp_valid_hold", {63'd0, wr_valid_o}, 64'd1);
          chk("bp_map_stable", {56'd0, sparsemap_o}, {56'd0, snap_map});
          chk("bp_data_stable", nonzero_data_o, snap_data);
          chk("bp_map_first", {56'd0, sparsemap_o}, 64'h49);
        end
        @(posedge clk_i);
        #1;
        if (r) begin
          idx++;
          drive(idx % 8, 1'b0);
        end
      end
    end
    idle(4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Short chunk (last on beat 5), then a 16-beat chunk whose final beat
    // also carries last, then one more full chunk to confirm the count restarted.
    do_reset();
    e0 = n_end;
    for (int i = 0; i < 5; i++) send_beat(i % 8, i == 4);
    for (int i = 0; i < 16; i++) send_beat((i + 3) % 8, i == 15);
    for (int i = 0; i < 16; i++) send_beat((i + 1) % 8, 1'b0);
    idle(3);
    chk("short_end_count", 64'(n_end - e0), 64'd3);

    // Asynchronous reset mid-chunk.
    do_reset();
    for (int i = 0; i < 3; i++) send_beat(i + 4, 1'b0);
    chk("pre_rst_valid", {63'd0, wr_valid_o}, 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, wr_valid_o}, 64'd0);
    chk("async_rst_map", {56'd0, sparsemap_o}, 64'd0);
    chk("async_rst_data", nonzero_data_o, 64'd0);
    chk("async_rst_end", {63'd0, chunk_end_o}, 64'd0);
    dense_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", {63'd0, dense_ready_o}, 64'd1);
    @(posedge clk_i);
    #1;
    e0 = n_end;
    for (int i = 0; i < 16; i++) send_beat(i % 8, 1'b0);
    idle(3);
    chk("post_rst_end_count", 64'(n_end - e0), 64'd1);

    // All-FF chunk: nonzero total reported on the chunk-end beat.
    do_reset();
    for (int i = 0; i < 16; i++) send_beat(2, 1'b0);
    idle(3);
`ifdef SPARSE_ENC_NZCOUNT_EN
    chk("nz_total", {56'd0, last_end_nz}, 64'd128);
`else
    chk("nz_total", {56'd0, last_end_nz}, 64'd0);
`endif
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sparse_chunk_encoder.md
Name: sparse_chunk_encoder

Overview:
- Transmit-side encoder for the compute unit's sparse write interface.
- Accepts dense byte beats and converts each beat to a sparsemap (1 bit per byte, set when the byte is nonzero) plus a compacted nonzero-byte vector.
- Drives the unit's sparsemap, nonzero-data and valid/ready write port.
- Counts beats per chunk and flags the final beat of each chunk.

Parameters:
- MEM_SIZE, 128, chunk size in bytes (per-operand buffer depth of the compute unit).
- BUS_SIZE, 8, bytes per beat; MEM_SIZE must be an integer multiple of BUS_SIZE.
- Derived constants:
  - BEATS = MEM_SIZE/BUS_SIZE.
  - CNT_W = $clog2(BEATS).
  - NZ_W = $clog2(MEM_SIZE)+1.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- dense_data_i  input  BUS_SIZE*8  dense beat; byte i = bits [8i+7:8i].
- dense_valid_i  input  1  dense beat valid.
- dense_last_i  input  1  force chunk end on this beat (short chunk).
- dense_ready_o  output  1  encoder can accept a beat this cycle.
- sparsemap_o  output  BUS_SIZE  bit i = (byte i of the source beat != 0).
- nonzero_data_o  output  BUS_SIZE*8  nonzero bytes packed from byte 0 upward; unused upper bytes 0.
- wr_valid_o  output  1  encoded beat valid.
- wr_ready_i  input  1  downstream accepts the encoded beat.
- chunk_end_o  output  1  qualifies the current encoded beat as the last of its chunk.
- nz_count_o  output  NZ_W  nonzero-byte count of the chunk (see Optional Feature).

Behaviour:
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Once asserted, wr_valid_o and its payload hold stable until accepted.
  - dense_valid_i is never required to wait for dense_ready_o.
- Pipeline (2 stages, stall-propagating, no bubbles at full throughput):
  - S1 registers the input beat, its sparsemap and its chunk-end flag.
  - S2 registers the compacted data, the sparsemap and chunk_end; S2 drives all outputs directly.
  - s2_load = s1_valid && (!s2_valid || wr_ready_i).
  - s1_load = dense_valid_i && dense_ready_o.
  - dense_ready_o = !s1_valid || !s2_valid || wr_ready_i (combinational from wr_ready_i).
  - Latency: an accepted input beat appears on the outputs 2 cycles later if unstalled.
  - Throughput: 1 beat/cycle.
- Compaction: output byte k = the k-th nonzero input byte in ascending byte index (prefix-sum of the sparsemap). Beat with popcount p: bytes p..BUS_SIZE-1 = 0x00.
- All-zero beat: still emitted, with sparsemap 0 and data 0. It counts as a beat.
- Beat counter (CNT_W bits, reset 0):
  - Increments on each input acceptance.
  - The beat's chunk-end flag is set when count == BEATS-1 or dense_last_i = 1.
  - When the flag is set, the counter returns to 0; otherwise it wraps naturally at BEATS.
- Simultaneous dense_last_i on beat BEATS-1: one chunk end only, counter to 0.
- Reset (async, any time, including mid-chunk):
  - All valids, the counter and the nonzero accumulator clear immediately.
  - Outputs: wr_valid_o=0, sparsemap_o=0, nonzero_data_o=0, chunk_end_o=0, nz_count_o=0.
  - dense_ready_o=1 on reset release.
  - Beats in flight are discarded.

Optional Feature:
- Macro: SPARSE_ENC_NZCOUNT_EN.
- Defined:
  - An NZ_W accumulator adds each S2-loaded beat's popcount.
  - On the chunk-end beat, nz_count_o = (accumulated total including that beat), held with the beat while chunk_end_o=1.
  - The accumulator clears when the chunk-end beat loads into S2.
  - nz_count_o = 0 when chunk_end_o = 0.
- Undefined: nz_count_o tied to 0; no accumulator logic.

Test Plan:
- Compaction:
  - Stimulus: dense_data_i=64'h0005_0000_0700_0003, single beat, wr_ready_i=1.
  - Response: 2 cycles later wr_valid_o=1, sparsemap_o=8'h49, nonzero_data_o=64'h0000_0000_0005_0703, chunk_end_o=0.
- Zero beat:
  - Stimulus: dense_data_i=0.
  - Response: encoded beat emitted with sparsemap_o=8'h00, nonzero_data_o=0; beat counter advances by 1.
- Full chunk:
  - Stimulus: 16 back-to-back beats (defaults), wr_ready_i=1.
  - Response: 16 output beats on consecutive cycles; chunk_end_o only on the 16th; the 17th beat starts a new chunk.
- Backpressure:
  - Stimulus: continuous input, wr_ready_i=0 for 5 cycles.
  - Response: exactly 2 beats buffered; dense_ready_o=0 while both stages are full; outputs stable; on release, beats come out in order with no loss or duplication.
- Short chunk:
  - Stimulus: dense_last_i=1 on the 5th beat.
  - Response: chunk_end_o on the 5th output beat; the next input beat counts as beat 0, and its chunk ends 16 beats later.
- Reset and counter:
  - Stimulus: assert rst_i mid-chunk, asynchronously.
  - Response: wr_valid_o drops without a clock edge; counter 0.
  - With SPARSE_ENC_NZCOUNT_EN, stimulus: a chunk of all-8'hFF beats. Response: nz_count_o=128 on its chunk-end beat.
